// File: rtl/vector_alu_pkg.sv
// Shared types and helpers for the pipelined vector ALU.
package vector_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10
    } op_t;

    localparam int unsigned DEF_LANES  = 16;
    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_STAGES = 2;

    function automatic int unsigned res_width(input int unsigned w);
        return 2 * w;
    endfunction

    localparam int unsigned RES_W = res_width(DEF_WIDTH);

    // Reserved encoding 2'b11 behaves as ADD.
    function automatic op_t decode_op(input logic [1:0] raw);
        case (raw)
            2'b01:   return OP_SUB;
            2'b10:   return OP_MUL;
            default: return OP_ADD;
        endcase
    endfunction

    // Lane-count independent part of the payload; the top wraps it with mask and results.
    typedef struct packed {
        op_t  op;
        logic is_signed;
    } payload_hdr_t;

endpackage

// File: rtl/vector_alu_lane.sv
// Single-lane combinational ADD/SUB/MUL producing a double-width result.
module vector_alu_lane
    import vector_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0]            a_i,
    input  logic [WIDTH-1:0]            b_i,
    input  op_t                         op_i,
    input  logic                        is_signed_i,
    input  logic                        en_i,
    output logic [res_width(WIDTH)-1:0] r_o
);

    localparam int unsigned RW = res_width(WIDTH);

    logic [WIDTH:0]  a_x, b_x, sum, diff;
    logic [RW-1:0]   a_w, b_w, prod;

    always_comb begin
        a_x  = {is_signed_i & a_i[WIDTH-1], a_i};
        b_x  = {is_signed_i & b_i[WIDTH-1], b_i};
        sum  = a_x + b_x;
        diff = a_x - b_x;
        // Extending to full width first makes one unsigned multiply serve both signednesses.
        a_w  = {{WIDTH{is_signed_i & a_i[WIDTH-1]}}, a_i};
        b_w  = {{WIDTH{is_signed_i & b_i[WIDTH-1]}}, b_i};
        prod = a_w * b_w;

        r_o = '0;
        if (en_i) begin
            case (op_i)
                OP_SUB:  r_o = {{(WIDTH-1){diff[WIDTH]}}, diff};
                OP_MUL:  r_o = prod;
                default: r_o = {{(WIDTH-1){is_signed_i & sum[WIDTH]}}, sum};
            endcase
        end
    end

endmodule

// File: rtl/vector_alu_pipe.sv
// Vector ALU: LANES parallel lanes computed up front, then a bubble-collapsing
// elastic chain of STAGES valid/payload registers toward the writeback port.
module vector_alu_pipe
    import vector_alu_pkg::*;
#(
    parameter int unsigned LANES  = 16,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 op,
    input  logic                       is_signed,
    input  logic [LANES-1:0]           lane_mask,
    input  logic [LANES*WIDTH-1:0]     data_in_1,
    input  logic [LANES*WIDTH-1:0]     data_in_2,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [LANES*2*WIDTH-1:0]   data_out
);

    localparam int unsigned RW = res_width(WIDTH);

    typedef struct packed {
        payload_hdr_t         hdr;
        logic [LANES-1:0]     lane_mask;
        logic [LANES*RW-1:0]  res;
    } payload_t;

    op_t                  op_dec;
    logic [LANES*RW-1:0]  lane_res;
    payload_t             in_pay;

    assign op_dec = decode_op(op);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_alu_lane #(.WIDTH(WIDTH)) u_lane (
            .a_i         (data_in_1[WIDTH*i +: WIDTH]),
            .b_i         (data_in_2[WIDTH*i +: WIDTH]),
            .op_i        (op_dec),
            .is_signed_i (is_signed),
            .en_i        (lane_mask[i]),
            .r_o         (lane_res[RW*i +: RW])
        );
    end

    always_comb begin
        in_pay               = '0;
        in_pay.hdr.op        = op_dec;
        in_pay.hdr.is_signed = is_signed;
        in_pay.lane_mask     = lane_mask;
        in_pay.res           = lane_res;
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES:0]   vchain;
    logic [STAGES-1:0] ready;
    payload_t          pay_q [STAGES];
    payload_t          pay_d [STAGES];
    payload_t          up_pay [STAGES];

    assign vchain = {valid_q, in_valid};

    always_comb begin : ready_chain
        logic r;
        r = out_ready;
        for (int unsigned i = 0; i < STAGES; i++) begin
            r = !valid_q[STAGES-1-i] || r;
            ready[STAGES-1-i] = r;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        up_pay[0] = in_pay;
        for (int unsigned k = 1; k < STAGES; k++) begin
            up_pay[k] = pay_q[k-1];
        end
        for (int unsigned k = 0; k < STAGES; k++) begin
            pay_d[k] = pay_q[k];
            if (ready[k]) begin
                valid_d[k] = vchain[k];
                // Payload only moves with a real vector so a stalled output stays put.
                if (vchain[k]) begin
                    pay_d[k] = up_pay[k];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pay_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pay_q[k] <= pay_d[k];
            end
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign data_out  = pay_q[STAGES-1].res;

    logic meta_unused;
    assign meta_unused = ^{pay_q[STAGES-1].hdr, pay_q[STAGES-1].lane_mask};

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Bench for vector_alu_pipe: directed table, hand-written stall/reset sequences,
// and random traffic against a plain-arithmetic lane model with a scoreboard.
module tb_vector_alu_pipe;

    localparam int unsigned L  = 16;
    localparam int unsigned W  = 32;
    localparam int unsigned S  = 2;
    localparam int unsigned L2 = 4;
    localparam int unsigned W2 = 8;
    localparam int unsigned S2 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic            in_valid, in_ready, out_valid, out_ready, is_signed;
    logic [1:0]      op;
    logic [L-1:0]    lane_mask;
    logic [L*W-1:0]  d1, d2;
    logic [L*2*W-1:0] data_out;

    logic            b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_is_signed;
    logic [1:0]      b_op;
    logic [L2-1:0]   b_mask;
    logic [L2*W2-1:0] b_d1, b_d2;
    logic [L2*2*W2-1:0] b_out;

    vector_alu_pipe #(.LANES(L), .WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .is_signed(is_signed), .lane_mask(lane_mask),
        .data_in_1(d1), .data_in_2(d2), .out_valid(out_valid),
        .out_ready(out_ready), .data_out(data_out)
    );

    vector_alu_pipe #(.LANES(L2), .WIDTH(W2), .STAGES(S2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .op(b_op), .is_signed(b_is_signed), .lane_mask(b_mask),
        .data_in_1(b_d1), .data_in_2(b_d2), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_out)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_vec(input string name, input logic [1023:0] got, input logic [1023:0] exp);
        int bad;
        chk_cnt++;
        bad = -1;
        for (int i = L - 1; i >= 0; i--) if (got[i*64 +: 64] !== exp[i*64 +: 64]) bad = i;
        if (bad < 0) pass_cnt++;
        else $display("FAIL %s lane %0d: got %h expected %h", name, bad, got[bad*64 +: 64], exp[bad*64 +: 64]);
    endtask

    // Reference: interpret operands as integers, do the arithmetic, keep 2*w bits.
    function automatic logic [63:0] lowmask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] ref_lane(input logic [63:0] a, input logic [63:0] b,
                                             input int w, input logic [1:0] o, input logic s);
        longint va, vb;
        logic [63:0] r;
        va = longint'(a & lowmask(w));
        vb = longint'(b & lowmask(w));
        if (s && a[w-1]) va -= longint'(64'd1 << w);
        if (s && b[w-1]) vb -= longint'(64'd1 << w);
        case (o)
            2'b01:   r = 64'(va - vb);
            2'b10:   r = 64'(va * vb);
            default: r = 64'(va + vb);
        endcase
        return r & lowmask(2 * w);
    endfunction

    function automatic logic [1023:0] ref_vec(input logic [1:0] o, input logic s, input logic [15:0] m,
                                              input logic [511:0] a, input logic [511:0] b);
        logic [1023:0] r;
        r = '0;
        for (int i = 0; i < L; i++)
            if (m[i]) r[i*64 +: 64] = ref_lane(64'(a[i*32 +: 32]), 64'(b[i*32 +: 32]), W, o, s);
        return r;
    endfunction

    // Scoreboard monitor, sampling mid-cycle.
    logic [1023:0] exp_q[$];
    logic          stall_prev = 1'b0;
    logic [1023:0] hold_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            check("in_ready_occupancy", 64'(in_ready), 64'(out_ready || (exp_q.size() < S)));
            if (stall_prev) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check_vec("hold_data", data_out, hold_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_output: got %h expected none", data_out[63:0]);
                end else begin
                    check_vec("scoreboard", data_out, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(ref_vec(op, is_signed, lane_mask, d1, d2));
            stall_prev = out_valid && !out_ready;
            hold_prev  = data_out;
        end
    end

    task automatic send_a(input logic [1:0] o, input logic s, input logic [15:0] m,
                          input logic [31:0] a, input logic [31:0] b,
                          output logic [1023:0] res, output int lat);
        int n;
        op = o; is_signed = s; lane_mask = m;
        for (int i = 0; i < L; i++) begin
            d1[i*32 +: 32] = a;
            d2[i*32 +: 32] = b;
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        res = data_out;
    endtask

    task automatic send_b(input logic [1:0] o, input logic s, input logic [7:0] a, input logic [7:0] b,
                          output logic [63:0] res, output int lat);
        b_op = o; b_is_signed = s; b_mask = '1;
        for (int i = 0; i < L2; i++) begin
            b_d1[i*8 +: 8] = a;
            b_d2[i*8 +: 8] = b;
        end
        b_in_valid = 1'b1;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        lat = 1;
        while (!b_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        res = b_out;
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 4))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic        sgn;
        logic [15:0] mask;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [1023:0] res, expv;
        logic [63:0]   bres;
        logic [31:0]   got[$];
        int            lat, sent;

        tbl[0] = '{"add_u_carry",  2'b00, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 32'h1, 64'h0000_0001_0000_0000};
        tbl[1] = '{"add_s_wrap",   2'b00, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'h1, 64'h0};
        tbl[2] = '{"sub_s_min",    2'b01, 1'b1, 16'hFFFF, 32'h8000_0000, 32'h0, 64'hFFFF_FFFF_8000_0000};
        tbl[3] = '{"sub_u_min",    2'b01, 1'b0, 16'hFFFF, 32'h8000_0000, 32'h0, 64'h0000_0000_8000_0000};
        tbl[4] = '{"sub_u_borrow", 2'b01, 1'b0, 16'hFFFF, 32'd5,         32'd7, 64'hFFFF_FFFF_FFFF_FFFE};
        tbl[5] = '{"mul_s_m1",     2'b10, 1'b1, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h1};
        tbl[6] = '{"mul_u_max",    2'b10, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        tbl[7] = '{"mul_mask1",    2'b10, 1'b0, 16'h0001, 32'd3,         32'd3, 64'd9};
        tbl[8] = '{"op11_as_add",  2'b11, 1'b0, 16'hFFFF, 32'd2,         32'd3, 64'd5};
        tbl[9] = '{"add_s_neg",    2'b00, 1'b1, 16'hA5A5, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFB};

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; op = '0; is_signed = 1'b0; lane_mask = '0; d1 = '0; d2 = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_op = '0; b_is_signed = 1'b0; b_mask = '0; b_d1 = '0; b_d2 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check_vec("rst_data_out", data_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Two vectors in flight, then reset mid-stream.
        out_ready = 1'b0; op = 2'b00; is_signed = 1'b0; lane_mask = '1;
        d1 = {L{32'h11}}; d2 = {L{32'h22}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        check_vec("async_rst_data", data_out, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_a(2'b00, 1'b0, 16'hFFFF, 32'd7, 32'd8, res, lat);
        check("after_rst_latency", 64'(lat), 64'(S));
        check_vec("after_rst_data", res, {L{64'd15}});

        foreach (tbl[t]) begin
            send_a(tbl[t].op, tbl[t].sgn, tbl[t].mask, tbl[t].a, tbl[t].b, res, lat);
            for (int i = 0; i < L; i++) expv[i*64 +: 64] = tbl[t].mask[i] ? tbl[t].exp : 64'd0;
            check({tbl[t].name, "_latency"}, 64'(lat), 64'(S));
            check_vec(tbl[t].name, res, expv);
        end
        repeat (2) @(posedge clk);
        #1;

        // Six back-to-back vectors with downstream stalled in cycles 2..5.
        sent = 0;
        op = 2'b00; is_signed = 1'b0; lane_mask = '1; d2 = '0;
        for (int c = 0; c < 40 && got.size() < 6; c++) begin
            out_ready = !(c >= 2 && c <= 5);
            in_valid  = (sent < 6);
            d1 = '0;
            d1[31:0] = 32'(sent + 1);
            @(negedge clk);
            if (c == 3) check("bp_in_ready_low", 64'(in_ready), 64'd0);
            if (out_valid && out_ready) got.push_back(data_out[31:0]);
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_count", 64'(got.size()), 64'd6);
        foreach (got[i]) check("bp_order", 64'(got[i]), 64'(i + 1));

        // Random traffic; the monitor scores every emitted vector.
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            op        = 2'($urandom);
            is_signed = 1'($urandom);
            lane_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'hFFFF;
            for (int i = 0; i < L; i++) begin
                d1[i*32 +: 32] = rand_word();
                d2[i*32 +: 32] = rand_word();
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("drain_out_valid", 64'(out_valid), 64'd0);

        // Small configuration: 4 lanes x 8 bits, single stage.
        send_b(2'b00, 1'b0, 8'hFF, 8'hFF, bres, lat);
        check("b_add_u_latency", 64'(lat), 64'(S2));
        check("b_add_u", bres, 64'h01FE_01FE_01FE_01FE);
        send_b(2'b10, 1'b1, 8'hFF, 8'hFF, bres, lat);
        check("b_mul_s", bres, 64'h0001_0001_0001_0001);
        send_b(2'b10, 1'b0, 8'hFF, 8'hFF, bres, lat);
        check("b_mul_u", bres, 64'hFE01_FE01_FE01_FE01);
        send_b(2'b01, 1'b0, 8'h00, 8'h01, bres, lat);
        check("b_sub_u_borrow", bres, 64'hFFFF_FFFF_FFFF_FFFF);
        check("b_sub_model", bres[15:0], ref_lane(64'h0, 64'h1, W2, 2'b01, 1'b0));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
